// File: rtl/wb_pkg.sv
// Shared types and helpers for the multi-lane writeback unit.
// Defining WB_UNALIGNED_EN turns LWL/LWR into legal merging loads.
package wb_pkg;

  localparam int WORD_W = 32;
  localparam int MOP_W  = 3;

`ifdef WB_UNALIGNED_EN
  localparam bit UNALIGNED_EN = 1'b1;
`else
  localparam bit UNALIGNED_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LB   = 3'd1,
    MEM_LBU  = 3'd2,
    MEM_LH   = 3'd3,
    MEM_LHU  = 3'd4,
    MEM_LW   = 3'd5,
    MEM_LWL  = 3'd6,
    MEM_LWR  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } wb_state_t;

  function automatic logic is_unaligned(mem_op_t op);
    return (op == MEM_LWL) || (op == MEM_LWR);
  endfunction

  // LWL/LWR only become legal when the merging hardware is built in.
  function automatic logic is_legal(mem_op_t op);
    return !is_unaligned(op) || UNALIGNED_EN;
  endfunction

  function automatic logic is_load(mem_op_t op);
    logic res;
    case (op)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: res = 1'b1;
      MEM_LWL, MEM_LWR:                         res = UNALIGNED_EN;
      default:                                  res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic writes_reg(mem_op_t op);
    return (op == MEM_NONE) || is_load(op);
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational byte/halfword extraction and extension for one lane.
// LWL/LWR merging with the old rt value exists only under WB_UNALIGNED_EN.
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  mop_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] result_o
);

  mem_op_t     op;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign op      = mem_op_t'(mop_i);
  assign byteSel = word_i[{offset_i, 3'b000} +: 8];
  assign halfSel = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    result_o = '0;
    case (op)
      MEM_LB:  result_o = {{24{byteSel[7]}}, byteSel};
      MEM_LBU: result_o = {24'd0, byteSel};
      MEM_LH:  result_o = {{16{halfSel[15]}}, halfSel};
      MEM_LHU: result_o = {16'd0, halfSel};
      MEM_LW:  result_o = word_i;
`ifdef WB_UNALIGNED_EN
      // LWL fills the upper bytes from the word, LWR fills the lower bytes.
      MEM_LWL: begin
        case (offset_i)
          2'd0:    result_o = {word_i[7:0],  rt_old_i[23:0]};
          2'd1:    result_o = {word_i[15:0], rt_old_i[15:0]};
          2'd2:    result_o = {word_i[23:0], rt_old_i[7:0]};
          default: result_o = word_i;
        endcase
      end
      MEM_LWR: begin
        case (offset_i)
          2'd0:    result_o = word_i;
          2'd1:    result_o = {rt_old_i[31:24], word_i[31:8]};
          2'd2:    result_o = {rt_old_i[31:16], word_i[31:16]};
          default: result_o = {rt_old_i[31:8],  word_i[31:24]};
        endcase
      end
`endif
      default: result_o = '0;
    endcase
  end

`ifndef WB_UNALIGNED_EN
  logic unusedRtOld;
  assign unusedRtOld = ^rt_old_i;
`endif

endmodule

// File: rtl/writeback_unit.sv
// Multi-lane writeback stage: holds a bundle until all its loads return, then commits every lane at once.
// WB_UNALIGNED_EN enables LWL/LWR; otherwise they are flagged on wb_err and never written.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int LANES = 2,
  parameter int REG_W = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES-1:0]         in_lane_en,
  input  logic [LANES*REG_W-1:0]   in_dst,
  input  logic [LANES*WORD_W-1:0]  in_val,
  input  logic [LANES*MOP_W-1:0]   in_mop,
  input  logic [LANES*WORD_W-1:0]  in_rt_old,
  input  logic [LANES-1:0]         dresp_valid,
  input  logic [LANES*WORD_W-1:0]  dresp_data,
  output logic [LANES-1:0]         wr_en,
  output logic [LANES*REG_W-1:0]   wr_reg,
  output logic [LANES*WORD_W-1:0]  wr_word,
  output logic                     wb_err
);

  wb_state_t         state_q, state_d;
  logic [LANES-1:0]  pend_q, pend_d;
  logic [LANES-1:0]  laneEn_q;
  logic [REG_W-1:0]  dst_q   [LANES];
  logic [WORD_W-1:0] val_q   [LANES];
  logic [WORD_W-1:0] rtOld_q [LANES];
  logic [WORD_W-1:0] data_q  [LANES];
  mem_op_t           mop_q   [LANES];

  logic              accept;
  logic [LANES-1:0]  newPend;
  logic [LANES-1:0]  wantWr;
  logic [LANES-1:0]  illegal;

  assign in_ready = (state_q == ST_EMPTY) || (state_q == ST_READY);
  assign accept   = in_valid && in_ready;

  always_comb begin
    newPend = '0;
    for (int i = 0; i < LANES; i++) begin
      newPend[i] = in_lane_en[i] && is_load(mem_op_t'(in_mop[i*MOP_W +: MOP_W]));
    end
  end

  // READY behaves like EMPTY for acceptance so bundles can stream back to back.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      ST_EMPTY, ST_READY: begin
        if (accept) begin
          pend_d  = newPend;
          state_d = (newPend != '0) ? ST_WAIT : ST_READY;
        end else begin
          pend_d  = '0;
          state_d = ST_EMPTY;
        end
      end
      ST_WAIT: begin
        pend_d = pend_q & ~dresp_valid;
        if (pend_d == '0) begin
          state_d = ST_READY;
        end
      end
      default: begin
        pend_d  = '0;
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_EMPTY;
      pend_q   <= '0;
      laneEn_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        dst_q[i]   <= '0;
        val_q[i]   <= '0;
        rtOld_q[i] <= '0;
        data_q[i]  <= '0;
        mop_q[i]   <= MEM_NONE;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (accept) begin
        laneEn_q <= in_lane_en;
        for (int i = 0; i < LANES; i++) begin
          dst_q[i]   <= in_dst[i*REG_W +: REG_W];
          val_q[i]   <= in_val[i*WORD_W +: WORD_W];
          rtOld_q[i] <= in_rt_old[i*WORD_W +: WORD_W];
          mop_q[i]   <= mem_op_t'(in_mop[i*MOP_W +: MOP_W]);
        end
      end
      // Only responses for still-pending lanes of a waiting entry are taken.
      for (int i = 0; i < LANES; i++) begin
        if ((state_q == ST_WAIT) && pend_q[i] && dresp_valid[i]) begin
          data_q[i] <= dresp_data[i*WORD_W +: WORD_W];
        end
      end
    end
  end

  always_comb begin
    wantWr  = '0;
    illegal = '0;
    for (int i = 0; i < LANES; i++) begin
      wantWr[i]  = (state_q == ST_READY) && laneEn_q[i] &&
                   writes_reg(mop_q[i]) && (dst_q[i] != '0);
      illegal[i] = laneEn_q[i] && !is_legal(mop_q[i]);
    end
  end

  // On a destination clash the highest-index lane wins, matching program order.
  always_comb begin
    wr_en = wantWr;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if ((j > i) && wantWr[j] && (dst_q[j] == dst_q[i])) begin
          wr_en[i] = 1'b0;
        end
      end
    end
  end

  assign wb_err = (state_q == ST_READY) && (illegal != '0);

  for (genvar g = 0; g < LANES; g++) begin : gLane
    logic [WORD_W-1:0] aligned;

    load_align uAlign (
      .mop_i    (mop_q[g]),
      .offset_i (val_q[g][1:0]),
      .word_i   (data_q[g]),
      .rt_old_i (rtOld_q[g]),
      .result_o (aligned)
    );

    assign wr_reg[g*REG_W +: REG_W]    = dst_q[g];
    assign wr_word[g*WORD_W +: WORD_W] = (mop_q[g] == MEM_NONE) ? val_q[g] : aligned;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit with two lanes; expected commits are queued at drive time.
// LWL/LWR expectations follow WB_UNALIGNED_EN.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int LANES = 2;
  localparam int REG_W = 5;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0]      in_lane_en;
  logic [LANES*REG_W-1:0] in_dst;
  logic [LANES*32-1:0]   in_val;
  logic [LANES*3-1:0]    in_mop;
  logic [LANES*32-1:0]   in_rt_old;
  logic [LANES-1:0]      dresp_valid;
  logic [LANES*32-1:0]   dresp_data;
  logic [LANES-1:0]      wr_en;
  logic [LANES*REG_W-1:0] wr_reg;
  logic [LANES*32-1:0]   wr_word;
  logic                  wb_err;

  typedef struct packed {
    logic [1:0]  en;
    logic [4:0]  r1;
    logic [4:0]  r0;
    logic [31:0] w1;
    logic [31:0] w0;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  int   total = 0;
  int   bad   = 0;

  writeback_unit #(.LANES(LANES), .REG_W(REG_W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_lane_en  (in_lane_en),
    .in_dst      (in_dst),
    .in_val      (in_val),
    .in_mop      (in_mop),
    .in_rt_old   (in_rt_old),
    .dresp_valid (dresp_valid),
    .dresp_data  (dresp_data),
    .wr_en       (wr_en),
    .wr_reg      (wr_reg),
    .wr_word     (wr_word),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mkExp(input logic [1:0] en, input logic [4:0] r0, input logic [4:0] r1,
                                 input logic [31:0] w0, input logic [31:0] w1);
    exp_t e;
    e.en = en;
    e.r0 = r0;
    e.r1 = r1;
    e.w0 = w0;
    e.w1 = w1;
    return e;
  endfunction

  task automatic applyStimulus(input logic [1:0] en, input logic [4:0] d0, input logic [4:0] d1,
                               input logic [31:0] v0, input logic [31:0] v1,
                               input mem_op_t m0, input mem_op_t m1,
                               input logic [31:0] rt0, input logic [31:0] rt1);
    in_lane_en = en;
    in_dst     = {d1, d0};
    in_val     = {v1, v0};
    in_mop     = {m1, m0};
    in_rt_old  = {rt1, rt0};
    in_valid   = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every observed write is matched against the oldest queued commit.
  always @(negedge clk) begin
    if (resetn === 1'b1 && wr_en !== 2'b00) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_wr", 64'(wr_en), 64'd0);
      end else begin
        monE = sb.pop_front();
        checkOutput("sb_en", 64'(wr_en), 64'(monE.en));
        if (monE.en[0]) begin
          checkOutput("sb_reg0", 64'(wr_reg[4:0]), 64'(monE.r0));
          checkOutput("sb_word0", 64'(wr_word[31:0]), 64'(monE.w0));
        end
        if (monE.en[1]) begin
          checkOutput("sb_reg1", 64'(wr_reg[9:5]), 64'(monE.r1));
          checkOutput("sb_word1", 64'(wr_word[63:32]), 64'(monE.w1));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_lane_en  = '0;
    in_dst      = '0;
    in_val      = '0;
    in_mop      = '0;
    in_rt_old   = '0;
    dresp_valid = '0;
    dresp_data  = '0;
    repeat (2) step();
    resetn = 1'b1;
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_wren", 64'(wr_en), 64'd0);
    checkOutput("rst_err", 64'(wb_err), 64'd0);

    // Single ALU op on lane 0.
    applyStimulus(2'b01, 5'd3, 5'd0, 32'h12, 32'h0, MEM_NONE, MEM_NONE, 32'h0, 32'h0);
    sb.push_back(mkExp(2'b01, 5'd3, 5'd0, 32'h00000012, 32'h0));
    checkOutput("t1_ready_pre", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    checkOutput("t1_wren", 64'(wr_en), 64'd1);
    checkOutput("t1_ready", 64'(in_ready), 64'd1);
    step();
    checkOutput("t1_idle", 64'(wr_en), 64'd0);

    // Two loads answered out of order, plus a stray response that must be ignored.
    applyStimulus(2'b11, 5'd4, 5'd5, 32'h1002, 32'h2002, MEM_LB, MEM_LHU, 32'h0, 32'h0);
    sb.push_back(mkExp(2'b11, 5'd4, 5'd5, 32'hFFFFFFFF, 32'h000080FF));
    step();
    in_valid = 1'b0;
    checkOutput("t2_ready_t1", 64'(in_ready), 64'd0);
    dresp_valid = 2'b10;
    dresp_data  = {32'h80FF7F01, 32'h80FF7F01};
    step();
    checkOutput("t2_ready_t2", 64'(in_ready), 64'd0);
    dresp_valid = 2'b10;
    dresp_data  = {32'h12345678, 32'h12345678};
    step();
    checkOutput("t2_ready_t3", 64'(in_ready), 64'd0);
    checkOutput("t2_nowr_t3", 64'(wr_en), 64'd0);
    dresp_valid = 2'b01;
    dresp_data  = {32'h80FF7F01, 32'h80FF7F01};
    step();
    dresp_valid = 2'b00;
    checkOutput("t2_commit", 64'(wr_en), 64'd3);
    checkOutput("t2_ready_t4", 64'(in_ready), 64'd1);
    step();

    // Same destination on both lanes, then a write to r0.
    applyStimulus(2'b11, 5'd7, 5'd7, 32'h1, 32'h2, MEM_NONE, MEM_NONE, 32'h0, 32'h0);
    sb.push_back(mkExp(2'b10, 5'd7, 5'd7, 32'h1, 32'h2));
    step();
    in_valid = 1'b0;
    checkOutput("t3_conflict", 64'(wr_en), 64'd2);
    step();
    applyStimulus(2'b01, 5'd0, 5'd0, 32'h5, 32'h0, MEM_NONE, MEM_NONE, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    checkOutput("t3_dst0", 64'(wr_en), 64'd0);
    step();

    // Reset while a load is pending; late responses must not produce a write.
    applyStimulus(2'b01, 5'd9, 5'd0, 32'h100, 32'h0, MEM_LW, MEM_NONE, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    checkOutput("t4_wait", 64'(in_ready), 64'd0);
    resetn      = 1'b0;
    dresp_valid = 2'b01;
    dresp_data  = {32'h0, 32'hDEADBEEF};
    step();
    resetn = 1'b1;
    checkOutput("t4_ready_rst", 64'(in_ready), 64'd1);
    checkOutput("t4_nowr_rst", 64'(wr_en), 64'd0);
    step();
    dresp_valid = 2'b00;
    checkOutput("t4_nowr1", 64'(wr_en), 64'd0);
    checkOutput("t4_ready1", 64'(in_ready), 64'd1);
    step();
    checkOutput("t4_nowr2", 64'(wr_en), 64'd0);

    // Signed half and unsigned top byte at minimum latency.
    applyStimulus(2'b11, 5'd12, 5'd13, 32'h400, 32'h503, MEM_LH, MEM_LBU, 32'h0, 32'h0);
    sb.push_back(mkExp(2'b11, 5'd12, 5'd13, 32'hFFFFF00D, 32'h000000AB));
    step();
    in_valid = 1'b0;
    checkOutput("t5_lat1", 64'(wr_en), 64'd0);
    dresp_valid = 2'b11;
    dresp_data  = {32'hAB000000, 32'h1234F00D};
    step();
    dresp_valid = 2'b00;
    checkOutput("t5_commit", 64'(wr_en), 64'd3);
    step();

    // Unaligned merges.
    applyStimulus(2'b11, 5'd10, 5'd11, 32'h201, 32'h301, MEM_LWL, MEM_LWR, 32'h11223344, 32'h11223344);
`ifdef WB_UNALIGNED_EN
    sb.push_back(mkExp(2'b11, 5'd10, 5'd11, 32'hCCDD3344, 32'h11AABBCC));
    step();
    in_valid = 1'b0;
    checkOutput("t6_wait", 64'(in_ready), 64'd0);
    checkOutput("t6_noerr", 64'(wb_err), 64'd0);
    dresp_valid = 2'b11;
    dresp_data  = {32'hAABBCCDD, 32'hAABBCCDD};
    step();
    dresp_valid = 2'b00;
    checkOutput("t6_commit", 64'(wr_en), 64'd3);
    checkOutput("t6_noerr2", 64'(wb_err), 64'd0);
    step();
`else
    step();
    in_valid = 1'b0;
    checkOutput("t6_err", 64'(wb_err), 64'd1);
    checkOutput("t6_nowr", 64'(wr_en), 64'd0);
    step();
    checkOutput("t6_err_pulse", 64'(wb_err), 64'd0);
    checkOutput("t6_nowr2", 64'(wr_en), 64'd0);
`endif

    // Ten streaming bundles with in_valid held high.
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin
        checkOutput("t7_stream", 64'(wr_en), 64'd3);
      end
      applyStimulus(2'b11, 5'(k + 1), 5'd20, 32'h100 + 32'(k), 32'(k), MEM_NONE, MEM_NONE, 32'h0, 32'h0);
      sb.push_back(mkExp(2'b11, 5'(k + 1), 5'd20, 32'h100 + 32'(k), 32'(k)));
      step();
    end
    in_valid = 1'b0;
    checkOutput("t7_last", 64'(wr_en), 64'd3);
    step();
    checkOutput("t7_drain", 64'(wr_en), 64'd0);

    repeat (3) step();
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
